// File: rtl/fifo_stream_reader.sv
// Read-side drain stage for synchronous_fifo: pops through r_en/data_out/empty, absorbs the
// one-cycle read latency in a 2-entry skid buffer and emits a valid/ready stream framed in bursts.
module fifo_stream_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_r_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic                  busy
);

    localparam int unsigned BURST_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(BURST_LEN - 1);

    // Skid buffer: head drives m_data, tail holds the second entry.
    logic [1:0]            occ;
    logic                  in_flight;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic [BURST_W-1:0]    burst_cnt;

    logic [1:0]            occ_n;
    logic [DATA_WIDTH-1:0] head_n;
    logic [DATA_WIDTH-1:0] tail_n;
    logic [BURST_W-1:0]    burst_n;
    logic                  xfer_c;
    logic [2:0]            budget_c;

    assign xfer_c   = m_valid && m_ready;
    // Slots committed next cycle: buffered + landing - leaving. Pop only if one stays free.
    assign budget_c  = 3'(occ) + 3'(in_flight) - 3'(xfer_c);
    assign fifo_r_en = !rst && enable && !fifo_empty && (budget_c < 3'd2);
    assign m_data    = head;

    // Next-state: retire head on transfer, then land the in-flight word at the tail.
    always_comb begin
        occ_n   = occ;
        head_n  = head;
        tail_n  = tail;
        burst_n = burst_cnt;
        if (xfer_c) begin
            head_n  = tail;
            occ_n   = occ - 2'd1;
            burst_n = (burst_cnt == BURST_MAX) ? '0 : burst_cnt + BURST_W'(1);
        end
        if (in_flight) begin
            if (occ_n == 2'd0) begin
                head_n = fifo_data;
            end else begin
                tail_n = fifo_data;
            end
            occ_n = occ_n + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ        <= '0;
            in_flight  <= 1'b0;
            head       <= '0;
            tail       <= '0;
            burst_cnt  <= '0;
            beat_count <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            occ        <= occ_n;
            in_flight  <= fifo_r_en;
            head       <= head_n;
            tail       <= tail_n;
            burst_cnt  <= burst_n;
            beat_count <= beat_count + CNT_WIDTH'(xfer_c);
            m_valid    <= (occ_n != 2'd0);
            m_last     <= (occ_n != 2'd0) && (burst_n == BURST_MAX);
            busy       <= (occ_n != 2'd0) || fifo_r_en;
        end
    end

    // Buffer never overflows, never pops an empty FIFO, and holds a stalled beat steady.
    a_occ_bound: assert property (@(posedge clk) disable iff (rst) occ <= 2'd2);
    a_no_empty_pop: assert property (@(posedge clk) disable iff (rst) !(fifo_r_en && fifo_empty));
    a_hold: assert property (@(posedge clk) disable iff (rst)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_last)));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: per-cycle vector table plus hand-written corner sequences
// against a behavioural model of the upstream FIFO (registered data_out, one-cycle read latency).
module tb_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       fifo_empty;
    logic       fifo_r_en;
    logic [7:0] fifo_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic [15:0] beat_count;
    logic       busy;

    logic       r_en4, valid4, last4, busy4;
    logic [7:0] data4;
    logic [3:0] beats4;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en),
        .fifo_data(fifo_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .beat_count(beat_count), .busy(busy)
    );

    // Narrow beat counter copy sharing all inputs, to observe wrap.
    fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(4), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty), .fifo_r_en(r_en4),
        .fifo_data(fifo_data), .m_valid(valid4), .m_ready(m_ready), .m_data(data4),
        .m_last(last4), .beat_count(beats4), .busy(busy4)
    );

    // FIFO model: reset flushes it, data_out appears the cycle after a pop.
    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (rst) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_r_en && !fifo_empty) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int npops = 0;
    logic [7:0] got_d[$];
    logic       got_l[$];

    typedef struct packed {
        logic        pre;
        logic        en;
        logic        rdy;
        logic        r_en;
        logic        vld;
        logic [7:0]  data;
        logic        last;
        logic        busy;
        logic [15:0] beats;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ctl = {pre, en, rdy, r_en, vld}; fl = {last, busy}
    task automatic add(input logic [4:0] ctl, input logic [7:0] d, input logic [1:0] fl,
                       input logic [15:0] beats);
        vec_t v;
        v = {ctl, d, fl, beats};
        tbl.push_back(v);
    endtask

    task automatic step(input logic en, input logic rdy, input int pre_n, input logic [7:0] pre_base);
        @(negedge clk);
        for (int k = 0; k < pre_n; k++) begin
            mem[wr_ptr] = pre_base + 8'(k);
            wr_ptr = wr_ptr + 8'd1;
        end
        enable  = en;
        m_ready = rdy;
        #1;
        if (m_valid && m_ready) begin
            got_d.push_back(m_data);
            got_l.push_back(m_last);
        end
        if (fifo_r_en && !fifo_empty) npops++;
        check("pop_while_empty", 32'(fifo_r_en && fifo_empty), 32'd0);
    endtask

    task automatic run(input logic en, input logic rdy);
        step(en, rdy, 0, 8'h00);
    endtask

    task automatic clear_log();
        got_d.delete();
        got_l.delete();
        npops = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Full-rate drain of 0x11..0x18
        add(5'b11110, 8'h00, 2'b00, 16'd0);
        add(5'b01110, 8'h00, 2'b01, 16'd0);
        add(5'b01111, 8'h11, 2'b01, 16'd0);
        add(5'b01111, 8'h12, 2'b01, 16'd1);
        add(5'b01111, 8'h13, 2'b01, 16'd2);
        add(5'b01111, 8'h14, 2'b11, 16'd3);
        add(5'b01111, 8'h15, 2'b01, 16'd4);
        add(5'b01111, 8'h16, 2'b01, 16'd5);
        add(5'b01101, 8'h17, 2'b01, 16'd6);
        add(5'b01101, 8'h18, 2'b11, 16'd7);
        add(5'b01100, 8'h00, 2'b00, 16'd8);
        // Sink stalled: two pops fill the buffer, then release
        add(5'b11010, 8'h00, 2'b00, 16'd8);
        add(5'b01010, 8'h00, 2'b01, 16'd8);
        add(5'b01001, 8'h11, 2'b01, 16'd8);
        add(5'b01001, 8'h11, 2'b01, 16'd8);
        add(5'b01001, 8'h11, 2'b01, 16'd8);
        add(5'b01111, 8'h11, 2'b01, 16'd8);
        add(5'b01111, 8'h12, 2'b01, 16'd9);
        add(5'b01111, 8'h13, 2'b01, 16'd10);
        add(5'b01111, 8'h14, 2'b11, 16'd11);
        add(5'b01111, 8'h15, 2'b01, 16'd12);
        add(5'b01111, 8'h16, 2'b01, 16'd13);
        add(5'b01101, 8'h17, 2'b01, 16'd14);
        add(5'b01101, 8'h18, 2'b11, 16'd15);
        add(5'b01100, 8'h00, 2'b00, 16'd16);

        rst = 1'b1;
        enable = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_last", 32'(m_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_beats", 32'(beat_count), 32'd0);
        check("rst_beats4", 32'(beats4), 32'd0);
        check("rst_r_en", 32'(fifo_r_en), 32'd0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].rdy, tbl[i].pre ? 8 : 0, 8'h11);
            check($sformatf("row%0d_r_en", i), 32'(fifo_r_en), 32'(tbl[i].r_en));
            check($sformatf("row%0d_valid", i), 32'(m_valid), 32'(tbl[i].vld));
            if (tbl[i].vld) check($sformatf("row%0d_data", i), 32'(m_data), 32'(tbl[i].data));
            check($sformatf("row%0d_last", i), 32'(m_last), 32'(tbl[i].last));
            check($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            check($sformatf("row%0d_beats", i), 32'(beat_count), 32'(tbl[i].beats));
        end

        // Sink ready toggling every cycle
        clear_log();
        for (int i = 0; i < 40; i++) step(1'b1, (i % 2) == 0, (i == 0) ? 8 : 0, 8'h11);
        check("toggle_count", 32'(got_d.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("toggle_data%0d", k), 32'(got_d[k]), 32'(8'h11 + 8'(k)));
            check($sformatf("toggle_last%0d", k), 32'(got_l[k]), 32'((k % 4) == 3));
        end
        check("toggle_beats", 32'(beat_count), 32'd24);

        // Enable dropped after three pops
        clear_log();
        step(1'b1, 1'b1, 8, 8'h11);
        for (int g = 0; g < 10 && npops < 3; g++) run(1'b1, 1'b1);
        repeat (6) run(1'b0, 1'b1);
        check("en_off_pops", 32'(npops), 32'd3);
        check("en_off_count", 32'(got_d.size()), 32'd3);
        for (int k = 0; k < 3; k++)
            check($sformatf("en_off_data%0d", k), 32'(got_d[k]), 32'(8'h11 + 8'(k)));
        check("en_off_busy", 32'(busy), 32'd0);
        check("en_off_valid", 32'(m_valid), 32'd0);
        run(1'b1, 1'b1);
        check("en_resume_pop", 32'(fifo_r_en), 32'd1);
        for (int g = 0; g < 10 && got_d.size() < 4; g++) run(1'b1, 1'b1);
        check("en_resume_data", 32'(got_d[3]), 32'h14);
        check("en_resume_last", 32'(got_l[3]), 32'd1);
        for (int g = 0; g < 20 && got_d.size() < 8; g++) run(1'b1, 1'b1);
        check("en_drain_count", 32'(got_d.size()), 32'd8);
        check("en_drain_data", 32'(got_d[7]), 32'h18);
        check("en_drain_last", 32'(got_l[7]), 32'd1);
        repeat (3) run(1'b1, 1'b1);
        check("en_drain_beats", 32'(beat_count), 32'd32);

        // Reset mid-operation with the buffer full
        clear_log();
        step(1'b1, 1'b1, 8, 8'h11);
        run(1'b1, 1'b1);
        run(1'b1, 1'b1);
        run(1'b1, 1'b0);
        run(1'b1, 1'b0);
        check("full_valid", 32'(m_valid), 32'd1);
        check("full_data", 32'(m_data), 32'h12);
        check("full_no_pop", 32'(fifo_r_en), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        m_ready = 1'b1;
        #1;
        check("rst_gates_pop", 32'(fifo_r_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst2_valid", 32'(m_valid), 32'd0);
        check("rst2_beats", 32'(beat_count), 32'd0);
        check("rst2_busy", 32'(busy), 32'd0);
        check("rst2_last", 32'(m_last), 32'd0);

        // Refill after reset: framing restarts, 17 beats wrap the 4-bit counter
        clear_log();
        step(1'b1, 1'b1, 17, 8'h21);
        for (int g = 0; g < 40 && got_d.size() < 17; g++) run(1'b1, 1'b1);
        check("refill_count", 32'(got_d.size()), 32'd17);
        for (int k = 0; k < 17; k++) begin
            check($sformatf("refill_data%0d", k), 32'(got_d[k]), 32'(8'h21 + 8'(k)));
            check($sformatf("refill_last%0d", k), 32'(got_l[k]), 32'((k % 4) == 3));
        end
        run(1'b0, 1'b1);
        check("refill_beats", 32'(beat_count), 32'd17);
        check("wrap_beats4", 32'(beats4), 32'd1);
        check("refill_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
